// File: rtl/hmac_msg_loader.sv
// Byte-stream front end for the single-block HMAC-SHA3-256 core: packs one frame into a
// 1088-bit rate block in Keccak lane order, SHA3-pads it, then starts the core and holds inputs.
module hmac_msg_loader (
    input  logic          clk,
    input  logic          rst,
    input  logic [127:0]  key_in,
    input  logic          key_load,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    input  logic          s_last,
    output logic          s_ready,
    output logic          hmac_start,
    output logic [127:0]  hmac_key,
    output logic [1087:0] hmac_message,
    input  logic          hmac_ready,
    output logic          busy,
    output logic          frame_done,
    output logic          err_overflow
);

    localparam int unsigned MAX_BYTES = 135;
    localparam int unsigned BLK_BYTES = 136;
    localparam int unsigned CNT_W     = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_DRAIN,
        S_PAD,
        S_START,
        S_WAIT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             wr_byte;
    logic             do_pad;
    logic             clr_buf;
    logic             ld_key;
    logic             ovf;

    // Bit offset of byte idx: lane idx/8 counted down from the top, bytes little-endian in a lane.
    function automatic logic [10:0] byte_off(input logic [CNT_W-1:0] idx);
        int unsigned lane;
        int unsigned pos;
        lane = 32'(idx[7:3]);
        pos  = 32'(idx[2:0]);
        return 11'((32'd16 - lane) * 32'd64 + pos * 32'd8);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = s_valid & s_ready;
        wr_byte    = 1'b0;
        do_pad     = 1'b0;
        clr_buf    = 1'b0;
        ld_key     = 1'b0;
        ovf        = 1'b0;
        case (state)
            S_IDLE: begin
                ld_key = key_load;
                if (accept) begin
                    wr_byte    = 1'b1;
                    state_next = s_last ? S_PAD : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    wr_byte = 1'b1;
                    if (s_last) begin
                        state_next = S_PAD;
                    end else if (cnt == CNT_W'(MAX_BYTES - 1)) begin
                        ovf        = 1'b1;
                        state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (accept && s_last) begin
                    clr_buf    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_PAD: begin
                do_pad     = 1'b1;
                state_next = S_START;
            end
            S_START: state_next = S_WAIT;
            S_WAIT: begin
                if (hmac_ready) begin
                    clr_buf    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; the final byte slot is only ever touched by padding.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            hmac_key     <= '0;
            hmac_message <= '0;
            s_ready      <= 1'b1;
            hmac_start   <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (ld_key) hmac_key <= key_in;
            if (clr_buf) begin
                hmac_message <= '0;
                cnt          <= '0;
            end else if (wr_byte) begin
                hmac_message[byte_off(cnt) +: 8] <= s_data;
                cnt                              <= cnt + CNT_W'(1);
            end else if (do_pad) begin
                hmac_message[byte_off(cnt) +: 8] <= hmac_message[byte_off(cnt) +: 8] | 8'h06;
                // Later assignment wins when cnt names the last byte, giving 8'h86.
                hmac_message[byte_off(CNT_W'(BLK_BYTES - 1)) +: 8] <=
                    (cnt == CNT_W'(BLK_BYTES - 1)) ? 8'h86 : 8'h80;
            end
            s_ready      <= (state_next == S_IDLE) || (state_next == S_COLLECT) ||
                            (state_next == S_DRAIN);
            busy         <= (state_next == S_PAD) || (state_next == S_START) ||
                            (state_next == S_WAIT);
            hmac_start   <= (state_next == S_START);
            frame_done   <= (state == S_WAIT) && hmac_ready;
            err_overflow <= ovf;
        end
    end

endmodule
